// File: rtl/tpc_cache_pkg.sv
// tpc_cache_pkg: shared widths and entry/result types for the translation-path cache.
package tpc_cache_pkg;
    localparam int VPN_PART_LEN = 9;
    localparam int PPN_LEN      = 44;
    localparam int TPC_ASID_LEN = 16;
    localparam int TPC_LEVELS   = 2;
    typedef struct packed {
        logic [TPC_ASID_LEN-1:0]                 asid;
        logic [TPC_LEVELS-1:0][VPN_PART_LEN-1:0] tag;
        logic [TPC_LEVELS-1:0][PPN_LEN-1:0]      ppn;
        logic [TPC_LEVELS-1:0]                   valid;
    } tpc_entry_t;
    typedef struct packed {
        logic [$clog2(TPC_LEVELS+1)-1:0] hit_lvl;
        logic [PPN_LEN-1:0]              ppn;
    } tpc_lookup_res_t;
endpackage

// File: rtl/tpc_victim_sel.sv
// tpc_victim_sel: picks the lowest free entry, else a round-robin pointer that
// only advances when it was the one supplying the victim.
module tpc_victim_sel #(
    parameter  int ENTRIES = 8,
    localparam int IW      = $clog2(ENTRIES)
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [ENTRIES-1:0] valid_i,
    input  logic               alloc_i,
    output logic [IW-1:0]      victim_o
);
    logic [IW-1:0] r_ptr;
    logic [IW-1:0] w_free_idx;
    logic          w_any_free;
    always_comb begin
        w_free_idx = '0;
        w_any_free = 1'b0;
        for (int i = ENTRIES - 1; i >= 0; i--) begin
            w_free_idx = valid_i[i] ? w_free_idx : IW'(i);
            w_any_free = w_any_free || !valid_i[i];
        end
    end
    assign victim_o = w_any_free ? w_free_idx : r_ptr;
    always_ff @(posedge clk_i) begin
        if (rst_i)
            r_ptr <= '0;
        else if (alloc_i && !w_any_free)
            r_ptr <= (r_ptr == IW'(ENTRIES - 1)) ? '0 : r_ptr + 1'b1;
    end
endmodule

// File: rtl/tpc_cache.sv
// tpc_cache: ASID-tagged cache of non-leaf page-table pointers; a lookup returns
// the deepest cached level so the walker can skip those memory accesses.
module tpc_cache
    import tpc_cache_pkg::*;
#(
    parameter  int ENTRIES  = 8,
    parameter  int LEVELS   = TPC_LEVELS,
    parameter  int ASID_LEN = TPC_ASID_LEN,
    localparam int IW       = $clog2(ENTRIES),
    localparam int LW       = (LEVELS > 1) ? $clog2(LEVELS) : 1,
    localparam int HW       = $clog2(LEVELS + 1)
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic                           flush_i,
    input  logic                           flush_asid_en_i,
    input  logic [ASID_LEN-1:0]            flush_asid_i,
    input  logic                           lookup_valid_i,
    output logic                           lookup_ready_o,
    input  logic [LEVELS*VPN_PART_LEN-1:0] lookup_vpn_i,
    input  logic [ASID_LEN-1:0]            lookup_asid_i,
    output logic                           res_valid_o,
    input  logic                           res_ready_i,
    output logic [HW-1:0]                  res_hit_lvl_o,
    output logic [PPN_LEN-1:0]             res_ppn_o,
    output logic [IW-1:0]                  res_idx_o,
    input  logic                           fill_valid_i,
    input  logic [LW-1:0]                  fill_lvl_i,
    input  logic [IW-1:0]                  fill_idx_i,
    input  logic [VPN_PART_LEN-1:0]        fill_tag_i,
    input  logic [PPN_LEN-1:0]             fill_ppn_i,
    input  logic [ASID_LEN-1:0]            fill_asid_i,
    output logic                           fill_done_o,
    output logic [IW-1:0]                  fill_idx_o
);
    logic [ASID_LEN-1:0]     r_asid [ENTRIES];
    logic [VPN_PART_LEN-1:0] r_tag  [ENTRIES][LEVELS];
    logic [PPN_LEN-1:0]      r_ppn  [ENTRIES][LEVELS];
    logic [LEVELS-1:0]       r_vld  [ENTRIES];
    logic                    r_res_valid;
    logic [HW-1:0]           r_hit;
    logic [PPN_LEN-1:0]      r_res_ppn;
    logic [IW-1:0]           r_res_idx;
    logic                    r_fill_done;
    logic [IW-1:0]           r_fill_idx;
    logic [ENTRIES-1:0]      w_v0;
    logic [IW-1:0]           w_victim;
    logic [IW-1:0]           w_tgt;
    logic                    w_lvl0;
    logic                    w_alloc;
    logic                    w_fill_ok;
    logic                    w_fill_we;
    logic                    w_accept;
    logic [LEVELS-1:0]       w_bit;
    logic                    w_run;
    logic [HW-1:0]           w_d;
    logic [HW-1:0]           w_best_d;
    logic [PPN_LEN-1:0]      w_pp;
    logic [PPN_LEN-1:0]      w_best_ppn;
    logic [IW-1:0]           w_best_idx;

    always_comb begin
        w_v0 = '0;
        for (int e = 0; e < ENTRIES; e++)
            w_v0[e] = r_vld[e][0];
    end

    tpc_victim_sel #(.ENTRIES(ENTRIES)) u_victim (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .valid_i  (w_v0),
        .alloc_i  (w_alloc),
        .victim_o (w_victim)
    );

    assign w_lvl0         = fill_lvl_i == '0;
    assign w_alloc        = fill_valid_i && !flush_i && w_lvl0;
    assign w_tgt          = w_lvl0 ? w_victim : fill_idx_i;
    assign w_fill_ok      = w_lvl0 || r_vld[fill_idx_i][fill_lvl_i - 1'b1];
    assign w_fill_we      = fill_valid_i && !flush_i && w_fill_ok;
    assign w_bit          = LEVELS'(1) << fill_lvl_i;
    assign lookup_ready_o = !r_res_valid || res_ready_i;
    assign w_accept       = lookup_valid_i && lookup_ready_o;

    // Depth is the run of matching levels from level 0; strict '>' keeps the lowest index on ties.
    always_comb begin
        w_best_d   = '0;
        w_best_ppn = '0;
        w_best_idx = '0;
        w_run      = 1'b0;
        w_d        = '0;
        w_pp       = '0;
        for (int e = 0; e < ENTRIES; e++) begin
            w_run = r_asid[e] == lookup_asid_i;
            w_d   = '0;
            w_pp  = '0;
            for (int l = 0; l < LEVELS; l++) begin
                w_run = w_run && r_vld[e][l]
                        && r_tag[e][l] == lookup_vpn_i[(LEVELS-1-l)*VPN_PART_LEN +: VPN_PART_LEN];
                w_d   = w_run ? HW'(l + 1) : w_d;
                w_pp  = w_run ? r_ppn[e][l] : w_pp;
            end
            w_best_idx = (w_d > w_best_d) ? IW'(e) : w_best_idx;
            w_best_ppn = (w_d > w_best_d) ? w_pp : w_best_ppn;
            w_best_d   = (w_d > w_best_d) ? w_d : w_best_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int e = 0; e < ENTRIES; e++)
                r_vld[e] <= '0;
        end else if (flush_i) begin
            for (int e = 0; e < ENTRIES; e++)
                if (!flush_asid_en_i || r_asid[e] == flush_asid_i)
                    r_vld[e] <= '0;
        end else if (w_fill_we) begin
            r_vld[w_tgt] <= (r_vld[w_tgt] & (w_bit - 1'b1)) | w_bit;
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_fill_we) begin
            r_tag[w_tgt][fill_lvl_i] <= fill_tag_i;
            r_ppn[w_tgt][fill_lvl_i] <= fill_ppn_i;
            if (w_lvl0)
                r_asid[w_tgt] <= fill_asid_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_res_valid <= 1'b0;
            r_hit       <= '0;
            r_res_ppn   <= '0;
            r_res_idx   <= '0;
            r_fill_done <= 1'b0;
            r_fill_idx  <= '0;
        end else begin
            r_fill_done <= fill_valid_i;
            if (fill_valid_i)
                r_fill_idx <= w_tgt;
            if (w_accept) begin
                r_res_valid <= 1'b1;
                r_hit       <= w_best_d;
                r_res_ppn   <= w_best_ppn;
                r_res_idx   <= w_best_idx;
            end else if (res_ready_i) begin
                r_res_valid <= 1'b0;
            end
        end
    end

    assign res_valid_o   = r_res_valid;
    assign res_hit_lvl_o = r_hit;
    assign res_ppn_o     = r_res_ppn;
    assign res_idx_o     = r_res_idx;
    assign fill_done_o   = r_fill_done;
    assign fill_idx_o    = r_fill_idx;
endmodule

// File: tb/tb_tpc_cache.sv
// tb_tpc_cache: directed test-plan steps plus random traffic, checked against
// an entry-table model of the cache kept in the bench.
module tb_tpc_cache;
    localparam int E = 8, L = 2, AL = 16, VP = 9, PL = 44;
    logic clk_i = 1'b0;
    always #5 clk_i = ~clk_i;
    logic          rst_i, flush_i, flush_asid_en_i, lookup_valid_i, res_ready_i, fill_valid_i;
    logic [AL-1:0] flush_asid_i, lookup_asid_i, fill_asid_i;
    logic [L*VP-1:0] lookup_vpn_i;
    logic          lookup_ready_o, res_valid_o, fill_done_o;
    logic [1:0]    res_hit_lvl_o;
    logic [PL-1:0] res_ppn_o, fill_ppn_i;
    logic [2:0]    res_idx_o, fill_idx_i, fill_idx_o;
    logic [0:0]    fill_lvl_i;
    logic [VP-1:0] fill_tag_i;

    tpc_cache #(.ENTRIES(E), .LEVELS(L), .ASID_LEN(AL)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i), .flush_asid_en_i(flush_asid_en_i),
        .flush_asid_i(flush_asid_i), .lookup_valid_i(lookup_valid_i), .lookup_ready_o(lookup_ready_o),
        .lookup_vpn_i(lookup_vpn_i), .lookup_asid_i(lookup_asid_i), .res_valid_o(res_valid_o),
        .res_ready_i(res_ready_i), .res_hit_lvl_o(res_hit_lvl_o), .res_ppn_o(res_ppn_o),
        .res_idx_o(res_idx_o), .fill_valid_i(fill_valid_i), .fill_lvl_i(fill_lvl_i),
        .fill_idx_i(fill_idx_i), .fill_tag_i(fill_tag_i), .fill_ppn_i(fill_ppn_i),
        .fill_asid_i(fill_asid_i), .fill_done_o(fill_done_o), .fill_idx_o(fill_idx_o)
    );

    bit            m_v    [E][L];
    logic [VP-1:0] m_tag  [E][L];
    logic [PL-1:0] m_ppn  [E][L];
    logic [AL-1:0] m_asid [E];
    int            m_ptr, m_hit, m_ridx, m_fidx;
    bit            m_rv, m_fd;
    logic [PL-1:0] m_rppn;
    int            checks = 0, errors = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_lookup(output int hit, output int idx, output logic [PL-1:0] ppn);
        hit = 0;
        idx = 0;
        ppn = '0;
        for (int e = 0; e < E; e++) begin
            int d = 0;
            if (m_asid[e] === lookup_asid_i)
                while (d < L && m_v[e][d] && m_tag[e][d] === lookup_vpn_i[(L-1-d)*VP +: VP]) d++;
            if (d > hit) begin
                hit = d;
                idx = e;
                ppn = m_ppn[e][d-1];
            end
        end
    endtask

    task automatic cyc();
        int nh, ni, tgt;
        logic [PL-1:0] np;
        bit acc;
        #1;
        if (!rst_i) chk("lookup_ready", lookup_ready_o, !m_rv || res_ready_i);
        acc = lookup_valid_i && (!m_rv || res_ready_i);
        model_lookup(nh, ni, np);
        @(posedge clk_i);
        #1;
        if (rst_i) begin
            for (int e = 0; e < E; e++) for (int l = 0; l < L; l++) m_v[e][l] = 0;
            m_ptr = 0; m_rv = 0; m_hit = 0; m_ridx = 0; m_rppn = '0; m_fd = 0; m_fidx = 0;
        end else begin
            if (acc) begin
                m_rv = 1; m_hit = nh; m_ridx = ni; m_rppn = np;
            end else if (res_ready_i) m_rv = 0;
            m_fd = fill_valid_i;
            if (fill_valid_i) begin
                if (fill_lvl_i == 0) begin
                    tgt = -1;
                    for (int e = E - 1; e >= 0; e--) if (!m_v[e][0]) tgt = e;
                    if (tgt < 0) begin
                        tgt = m_ptr;
                        if (!flush_i) m_ptr = (m_ptr + 1) % E;
                    end
                end else tgt = fill_idx_i;
                m_fidx = tgt;
                if (!flush_i && (fill_lvl_i == 0 || m_v[tgt][fill_lvl_i-1])) begin
                    m_tag[tgt][fill_lvl_i] = fill_tag_i;
                    m_ppn[tgt][fill_lvl_i] = fill_ppn_i;
                    if (fill_lvl_i == 0) m_asid[tgt] = fill_asid_i;
                    for (int l = 0; l < L; l++) m_v[tgt][l] = (l < fill_lvl_i) ? m_v[tgt][l] : (l == fill_lvl_i);
                end
            end
            if (flush_i)
                for (int e = 0; e < E; e++)
                    if (!flush_asid_en_i || m_asid[e] === flush_asid_i)
                        for (int l = 0; l < L; l++) m_v[e][l] = 0;
        end
        chk("res_valid", res_valid_o, m_rv);
        chk("res_hit_lvl", res_hit_lvl_o, m_hit);
        chk("res_ppn", res_ppn_o, m_rppn);
        chk("res_idx", res_idx_o, m_ridx);
        chk("fill_done", fill_done_o, m_fd);
        chk("fill_idx", fill_idx_o, m_fidx);
    endtask

    task automatic reset_dut();
        rst_i = 1; cyc(); cyc(); rst_i = 0;
    endtask

    task automatic look(input logic [VP-1:0] p0, input logic [VP-1:0] p1, input logic [AL-1:0] a);
        lookup_valid_i = 1; lookup_vpn_i = {p0, p1}; lookup_asid_i = a; cyc(); lookup_valid_i = 0;
    endtask

    task automatic fill(input int lvl, input int idx, input logic [VP-1:0] tag, input logic [PL-1:0] ppn, input logic [AL-1:0] a);
        fill_valid_i = 1; fill_lvl_i = 1'(lvl); fill_idx_i = 3'(idx);
        fill_tag_i = tag; fill_ppn_i = ppn; fill_asid_i = a;
        cyc();
        fill_valid_i = 0;
    endtask

    initial begin
        rst_i = 1; flush_i = 0; flush_asid_en_i = 0; flush_asid_i = '0;
        lookup_valid_i = 0; lookup_vpn_i = '0; lookup_asid_i = '0; res_ready_i = 1;
        fill_valid_i = 0; fill_lvl_i = '0; fill_idx_i = '0; fill_tag_i = '0; fill_ppn_i = '0; fill_asid_i = '0;
        reset_dut();
        chk("rst_res_valid", res_valid_o, 0);
        chk("rst_fill_done", fill_done_o, 0);

        look(9'h1A, 9'h05, 3);
        chk("miss_valid", res_valid_o, 1);
        chk("miss_hit", res_hit_lvl_o, 0);
        chk("miss_ppn", res_ppn_o, 0);
        fill(0, 0, 9'h1A, 44'h100, 3);
        chk("l0_idx", fill_idx_o, 0);
        chk("l0_done", fill_done_o, 1);
        fill(1, 0, 9'h05, 44'h200, 3);
        look(9'h1A, 9'h05, 3);
        chk("hit2_lvl", res_hit_lvl_o, 2);
        chk("hit2_ppn", res_ppn_o, 44'h200);
        chk("hit2_idx", res_idx_o, 0);
        look(9'h1A, 9'h05, 4);
        chk("asid_miss", res_hit_lvl_o, 0);

        reset_dut();
        for (int i = 0; i < E + 2; i++) begin
            fill(0, 0, 9'(i + 16), 44'(i), 1);
            chk("wrap_idx", fill_idx_o, 64'(i % E));
        end
        flush_i = 1; flush_asid_en_i = 0; cyc(); flush_i = 0;
        fill(0, 0, 9'h40, 44'h40, 1);
        chk("refill_idx", fill_idx_o, 0);

        reset_dut();
        fill(0, 0, 9'h10, 44'h31, 3);
        fill(0, 0, 9'h10, 44'h51, 5);
        flush_i = 1; flush_asid_en_i = 1; flush_asid_i = 3; cyc(); flush_i = 0; flush_asid_en_i = 0;
        look(9'h10, 9'h00, 3);
        chk("aflush_miss", res_hit_lvl_o, 0);
        look(9'h10, 9'h00, 5);
        chk("aflush_keep_lvl", res_hit_lvl_o, 1);
        chk("aflush_keep_idx", res_idx_o, 1);
        chk("aflush_keep_ppn", res_ppn_o, 44'h51);

        fill(1, 0, 9'h22, 44'h77, 3);
        chk("drop_done", fill_done_o, 1);
        chk("drop_idx", fill_idx_o, 0);
        look(9'h10, 9'h22, 3);
        chk("drop_miss", res_hit_lvl_o, 0);
        flush_i = 1; flush_asid_en_i = 0;
        fill(0, 0, 9'h33, 44'h99, 7);
        flush_i = 0;
        chk("flushfill_done", fill_done_o, 1);
        look(9'h33, 9'h00, 7);
        chk("flushfill_miss", res_hit_lvl_o, 0);

        fill(0, 0, 9'h12, 44'hAB, 2);
        fill(1, 0, 9'h34, 44'hCD, 2);
        res_ready_i = 0; lookup_valid_i = 1; lookup_vpn_i = {9'h12, 9'h34}; lookup_asid_i = 2;
        cyc();
        chk("hold_first_hit", res_hit_lvl_o, 2);
        lookup_vpn_i = '0;
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("hold_ready", lookup_ready_o, 0);
            chk("hold_hit", res_hit_lvl_o, 2);
            chk("hold_ppn", res_ppn_o, 44'hCD);
        end
        res_ready_i = 1;
        cyc();
        chk("release_valid", res_valid_o, 1);
        chk("release_hit", res_hit_lvl_o, 0);
        res_ready_i = 0;
        cyc();
        rst_i = 1; lookup_valid_i = 0;
        cyc();
        chk("rst_drop", res_valid_o, 0);
        rst_i = 0; res_ready_i = 1;

        for (int n = 0; n < 500; n++) begin
            lookup_valid_i  = 1'($urandom_range(0, 1));
            lookup_vpn_i    = {9'($urandom_range(0, 3)), 9'($urandom_range(0, 3))};
            lookup_asid_i   = 16'($urandom_range(0, 2));
            res_ready_i     = $urandom_range(0, 3) != 0;
            fill_valid_i    = $urandom_range(0, 2) == 0;
            fill_lvl_i      = 1'($urandom_range(0, 1));
            fill_idx_i      = 3'($urandom_range(0, 7));
            fill_tag_i      = 9'($urandom_range(0, 3));
            fill_ppn_i      = 44'($urandom);
            fill_asid_i     = 16'($urandom_range(0, 2));
            flush_i         = $urandom_range(0, 30) == 0;
            flush_asid_en_i = 1'($urandom_range(0, 1));
            flush_asid_i    = 16'($urandom_range(0, 2));
            cyc();
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
